// File: rtl/key_step_conditioner.sv
// ---------------------------------------------------------------------------
// key_step_conditioner
//
// Conditions raw, bouncy, active-low pushbuttons for FSMs running on the
// system clock. Each key goes through a two-flop synchronizer and then a
// debouncer. The debouncer accepts a new level only after that level has
// been seen for DEBOUNCE_CYCLES consecutive cycles. Each accepted transition
// drives a registered one-cycle press or release pulse. Downstream logic can
// therefore step exactly once per physical press, and it never needs to use
// a key as a clock.
//
// Optional feature (macro KEY_REPEAT_EN):
//   While a key stays pressed, extra one-cycle press pulses fire
//   REPEAT_DELAY cycles after the accepted press, and then every
//   REPEAT_PERIOD cycles. With the macro undefined, no repeat logic exists
//   and the REPEAT_* parameters have no effect.
//
// Ports:
//   clk           in   system clock; all state changes on its rising edge
//   reset_n       in   synchronous active-low reset
//   key_n         in   [NKEYS] raw asynchronous keys, 0 = pressed
//   key_level     out  [NKEYS] debounced level, 1 = pressed
//   press         out  [NKEYS] one-cycle pulse on accepted press / repeat
//   release_pulse out  [NKEYS] one-cycle pulse on accepted release
//                      (the port is not called "release" because that word
//                      is a reserved keyword)
// ---------------------------------------------------------------------------
module key_step_conditioner #(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NKEYS-1:0] key_n,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] press,
  output logic [NKEYS-1:0] release_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations whose terminal count cannot fit in the counter.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_debounce_cfg
    $error("key_step_conditioner: DEBOUNCE_CYCLES out of range for CNT_W");
  end

  // Two-stage synchronizer. Both stages reset to "released", so a key held
  // through reset is seen as a fresh press once reset ends.
  logic [NKEYS-1:0] sync_q1_reg;
  logic [NKEYS-1:0] sync_q2_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q1_reg <= '1;
      sync_q2_reg <= '1;
    end else begin
      sync_q1_reg <= key_n;
      sync_q2_reg <= sync_q1_reg;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_FIRST_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat_cfg
    $error("key_step_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end
`endif

  for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
    logic [CNT_W-1:0] count_reg;
    logic             stable_reg;   // 1 = pressed
    logic             press_reg;
    logic             release_reg;
    logic             sample_pressed;
    logic             mismatch;
    logic             accept;
    logic             repeat_fire;

    assign sample_pressed = ~sync_q2_reg[gi];
    assign mismatch       = (sample_pressed != stable_reg);
    // The counter only advances while the sample disagrees with the stable
    // level, so it stops at CNT_LAST and cannot wrap.
    assign accept         = mismatch && (count_reg == CNT_LAST);

`ifdef KEY_REPEAT_EN
    logic [REP_W-1:0] rep_cnt_reg;
    logic             rep_first_done_reg;  // the first (REPEAT_DELAY) repeat has fired

    // When accept is high, the stable level is about to change. Suppressing
    // the repeat on that cycle keeps it from landing on the original press
    // and from appearing right as a release is accepted.
    assign repeat_fire = stable_reg && !accept &&
                         (rep_cnt_reg == (rep_first_done_reg ? REP_PERIOD_LAST : REP_FIRST_LAST));

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        rep_cnt_reg        <= '0;
        rep_first_done_reg <= 1'b0;
      end else if (accept || !stable_reg) begin
        rep_cnt_reg        <= '0;
        rep_first_done_reg <= 1'b0;
      end else if (repeat_fire) begin
        rep_cnt_reg        <= '0;
        rep_first_done_reg <= 1'b1;
      end else begin
        rep_cnt_reg        <= rep_cnt_reg + 1'b1;
      end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        count_reg   <= '0;
        stable_reg  <= 1'b0;
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
      end else begin
        press_reg   <= (accept && sample_pressed) || repeat_fire;
        release_reg <= accept && !sample_pressed;
        if (!mismatch) begin
          // The sample bounced back to the stable level, so restart the count.
          count_reg <= '0;
        end else if (accept) begin
          stable_reg <= sample_pressed;
          count_reg  <= '0;
        end else begin
          count_reg  <= count_reg + 1'b1;
        end
      end
    end

    assign key_level[gi]     = stable_reg;
    assign press[gi]         = press_reg;
    assign release_pulse[gi] = release_reg;
  end

endmodule

// File: tb/tb_key_step_conditioner.sv
// ---------------------------------------------------------------------------
// tb_key_step_conditioner
//
// Drives directed scenarios followed by randomized bouncy key activity. Every
// output is checked on every edge against a reference model built from a
// sliding window of raw key samples.
// The model rule: a key changes level at edge n when the raw samples taken at
// edges n-D-1 .. n-2 all show the same value, and that value differs from
// the current debounced level. Any reset flushes the sample history to
// "released".
// ---------------------------------------------------------------------------
module tb_key_step_conditioner;

  localparam int N   = 4;
  localparam int D   = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] key_n;
  logic [N-1:0] key_level;
  logic [N-1:0] press;
  logic [N-1:0] release_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  key_step_conditioner #(
    .NKEYS(N), .DEBOUNCE_CYCLES(D), .CNT_W(8),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_n(key_n),
    .key_level(key_level), .press(press), .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [N-1:0] hist[$];       // hist[i] = effective raw sample i edges ago
  logic [N-1:0] lvl_m;
  logic [N-1:0] exp_press;
  logic [N-1:0] exp_rel;
  int           edge_no;
  int           press_edge[N];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%h expected=%h", tag, edge_no, got, exp);
    end
  endtask

  task automatic model_edge(input logic rn, input logic [N-1:0] kn);
    edge_no++;
    exp_press = '0;
    exp_rel   = '0;
    if (!rn) begin
      for (int i = 0; i < hist.size(); i++) hist[i] = '1;
      lvl_m = '0;
    end else begin
      hist.push_front(kn);
      if (hist.size() > D + 2) void'(hist.pop_back());
      for (int k = 0; k < N; k++) begin
        logic want;
        logic steady;
        want   = ~hist[2][k];
        steady = 1'b1;
        for (int i = 2; i <= D + 1; i++)
          if (~hist[i][k] != want) steady = 1'b0;
        if (steady && want != lvl_m[k]) begin
          lvl_m[k] = want;
          if (want) begin
            exp_press[k]  = 1'b1;
            press_edge[k] = edge_no;
          end else begin
            exp_rel[k] = 1'b1;
          end
        end
`ifdef KEY_REPEAT_EN
        else if (lvl_m[k] && (edge_no - press_edge[k]) >= RD &&
                 ((edge_no - press_edge[k] - RD) % RP) == 0) begin
          exp_press[k] = 1'b1;
        end
`endif
      end
    end
  endtask

  // Apply inputs for one edge, advance, then compare 1 time unit after the edge.
  task automatic tick(input logic rn, input logic [N-1:0] kn);
    reset_n = rn;
    key_n   = kn;
    @(posedge clk);
    #1;
    model_edge(rn, kn);
    check_val("key_level", 32'(key_level), 32'(lvl_m));
    check_val("press", 32'(press), 32'(exp_press));
    check_val("release", 32'(release_pulse), 32'(exp_rel));
    if (press != '0 || release_pulse != '0)
      $display("edge %0d: key_n=%b level=%b press=%b release=%b", edge_no, kn, key_level, press, release_pulse);
  endtask

  task automatic hold(input logic rn, input logic [N-1:0] kn, input int cycles);
    for (int c = 0; c < cycles; c++) tick(rn, kn);
  endtask

  initial begin
    logic [N-1:0] kr;
    int           rate;
    logic         rn;

    edge_no = 0;
    lvl_m   = '0;
    for (int i = 0; i < D + 2; i++) hist.push_back('1);
    for (int k = 0; k < N; k++) press_edge[k] = 0;
    reset_n = 1'b0;
    key_n   = '1;

    // Reset with every key held; press on all keys 6 edges after release.
    hold(1'b0, 4'b0000, 2);
    hold(1'b1, 4'b0000, 10);
    hold(1'b1, 4'b1111, 10);

    // Clean press/release on key 0.
    hold(1'b1, 4'b1110, 10);
    hold(1'b1, 4'b1111, 10);

    // Bounce on key 0, then steady press.
    for (int r = 0; r < 2; r++) begin
      hold(1'b1, 4'b1110, 2);
      hold(1'b1, 4'b1111, 2);
    end
    hold(1'b1, 4'b1110, 10);
    hold(1'b1, 4'b1111, 10);

    // Two keys together, then a one-cycle glitch on key 2.
    hold(1'b1, 4'b1100, 10);
    hold(1'b1, 4'b1000, 1);
    hold(1'b1, 4'b1100, 8);
    hold(1'b1, 4'b1111, 10);

    // Reset in the middle of a key-1 debounce, with the key still held.
    hold(1'b1, 4'b1101, 3);
    hold(1'b0, 4'b1101, 2);
    hold(1'b1, 4'b1101, 10);
    hold(1'b1, 4'b1111, 10);

    // Long hold of key 0 (covers auto-repeat when enabled).
    hold(1'b1, 4'b1110, 40);
    hold(1'b1, 4'b1111, 12);

    // Randomized bouncy activity with occasional resets.
    kr   = '1;
    rate = 8;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 2))
          0:       rate = 2;
          1:       rate = 8;
          default: rate = 30;
        endcase
      end
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, rate) == 0) kr[k] = ~kr[k];
      rn = ($urandom_range(0, 499) != 0);
      tick(rn, kr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_step_conditioner.md
Name: key_step_conditioner

Overview:
- Upstream stage for the pushbutton-stepped display FSMs (e.g. the 5-state 2-4-0-3-1 sequencer).
- Takes raw, bouncy, active-low KEY inputs and synchronizes them to a free-running board clock (CLOCK_50), then debounces them.
- Emits clean one-cycle press/release pulses and debounced levels, so downstream FSMs advance exactly once per physical press on the system clock, instead of using KEY[0] as a clock.

Parameters:
- NKEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a level change; legal range 2..2^CNT_W-1.
- CNT_W, 20, width of each per-key debounce counter.
- REPEAT_DELAY, 25000000, cycles from accepted press to first auto-repeat pulse (only with KEY_REPEAT_EN).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (only with KEY_REPEAT_EN).

Ports:
- clk  input  1  single system clock; all state on its rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
- key_n  input  NKEYS  raw asynchronous pushbuttons, 0 = pressed.
- key_level  output  NKEYS  debounced level, 1 = pressed.
- press  output  NKEYS  one-cycle pulse on accepted press (and on auto-repeat when enabled).
- release  output  NKEYS  one-cycle pulse on accepted release.

Behaviour:
- One clock and one synchronous, active-low reset; the clock port is clk and the reset port is reset_n.
- Reset (reset_n=0 at a rising edge):
  - Sync flops load all 1s (released).
  - stable state loads released.
  - Counters load 0.
  - key_level, press and release load 0.
  - Any debounce in progress is discarded.
- Synchronizer: two flops per key. The raw level seen at edge 0 reaches the debounce logic after edge 1.
- Per-key debounce: mismatch means sync_q2 != stable.
  - Mismatch and count < DEBOUNCE_CYCLES-1: count increments.
  - Mismatch and count == DEBOUNCE_CYCLES-1: stable takes sync_q2, count clears to 0, and a pulse is generated.
  - Match (bounce back): count clears to 0 immediately and no pulse is generated.
- Latency: a level first sampled at edge 0 and held steady changes key_level, and pulses press or release, on edge DEBOUNCE_CYCLES+1. That is DEBOUNCE_CYCLES+2 edges in total.
- Pulse widths:
  - press and release are registered and high for exactly one cycle per accepted transition.
  - press and release are never both high on the same key.
  - Keys are fully independent, so simultaneous transitions on different keys each pulse in the same cycle.
- Counter width: count never exceeds DEBOUNCE_CYCLES-1; no wrap is possible.
- Key held through reset: after reset_n returns high, the key is treated as a fresh press. press fires DEBOUNCE_CYCLES+2 edges later.
- Reset asserted mid-debounce: no pulse is produced for the aborted transition.
- Downstream use: a consumer FSM steps when press[0] & enable. key_level[1] serves as a level-type reset request.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - Each key has a repeat counter, cleared on accepted press and on reset.
  - While key_level=1, an extra one-cycle press pulse fires REPEAT_DELAY cycles after the accepted press, then every REPEAT_PERIOD cycles.
  - On accepted release the repeat counter clears and no further repeat pulses fire. release behaves normally.
  - A repeat pulse never coincides with the original press pulse.
- Undefined:
  - No repeat logic is synthesized; the REPEAT_* parameters are ignored.
  - press fires only on debounced transitions.

Test Plan:
- Reset: DEBOUNCE_CYCLES=4, reset_n=0 for 2 edges with key_n=4'b0000 -> key_level=0, press=0, release=0 throughout. After reset_n=1, press=4'b1111 for exactly one cycle, 6 edges later.
- Clean press/release on key 0: key_n[0] 1->0 before edge 0 and held -> press[0]=1 only in the cycle after edge 5, key_level[0]=1 thereafter. Then 0->1 held -> release[0] pulses 6 edges later and key_level[0]=0.
- Bounce rejection: key_n[0] toggles 0,1,0,1 every 2 cycles, then stays 0 -> no pulse during the toggling; exactly one press[0] 6 edges after the final fall.
- Independence: key_n=4'b1100 simultaneously -> press=4'b0011 in one single cycle. Key 2 glitches low for 1 cycle -> press[2] and key_level[2] stay 0.
- Reset mid-debounce: key_n[1] falls, reset_n=0 at edge 3 -> press[1] never pulses for that attempt. Key still held after reset -> press[1] pulses 6 edges after reset_n=1.
- KEY_REPEAT_EN, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, key 0 held for 30 cycles -> press[0] at edges 5, 15, 20, 25, 30. Release -> no further press[0]; release[0] pulses once.
